hdmi_tx_pixel_gen: RTL and testbench
====================================

// Module: hdmi_tx_pixel_gen
// PURPOSE
// Transmit-side counterpart of the HDMI receive path: reads 24-bit RGB pixels from the frame FIFO
// and emits a raster with hsync/vsync/de timing into the TMDS encoders on pclk.
// Handles FIFO underrun by blanking the pixel data and re-locking at the next frame start.
// Reports underrun events to the host.
// PARAMETERS
// H_ACTIVE 1024 visible pixels/line; H_FP 24 h front porch; H_SYNC 136 hsync width; H_BP 160 h back porch
// V_ACTIVE 768 visible lines; V_FP 3 v front porch; V_SYNC 6 vsync lines; V_BP 29 v back porch
// HS_POL 0 / VS_POL 0   asserted level of hsync/vsync (0 = active-low)
// UNDERRUN_COLOR 24'h000000   {r,g,b} driven on a de pixel when no FIFO data is available
// CNT_W 12   width of h/v counters; must hold H_TOTAL-1 and V_TOTAL-1
// PORTS
// pclk               in   1   pixel clock; only clock
// reset              in   1   asynchronous, active-high
// enable             in   1   1 = allow lock/FIFO reads; timing runs regardless
// fifo_data_out      in   24  {red,green,blue}; valid 1 cycle after fifo_read_enable
// fifo_empty         in   1   FIFO holds no word
// fifo_read_enable   out  1   pop one word (combinational from counters/state/fifo_empty)
// hsync, vsync, de   out  1   registered timing for TMDS encoders
// red, green, blue   out  8   registered pixel data; 0 when de=0
// frame_start        out  1   1-cycle pulse, aligned with the first de pixel of a frame
// underrun           out  1   1-cycle pulse per underrun pixel
// underrun_count     out  16  saturating count of underrun pixels since reset
// BEHAVIOUR
// - Reset: h_cnt=v_cnt=0, state=STATE_WAIT_SYNC.
//   Outputs: hsync=~HS_POL, vsync=~VS_POL, de=0, rgb=0, frame_start=0, underrun=0, underrun_count=0.
// - Totals: H_TOTAL = sum of the H params; V_TOTAL = sum of the V params.
//   h_cnt wraps H_TOTAL-1 -> 0 and then increments v_cnt; v_cnt wraps V_TOTAL-1 -> 0.
// - Stage 0 (counters):
//   de0 = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
//   hs0 asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
//   vs0 asserted for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC; it changes at h_cnt==0.
// - fifo_read_enable = de0 && state==STATE_RUN && !fifo_empty.
//   Never asserted while fifo_empty=1, outside de, or in any other state.
// - Stage 1 holds delayed de/hs/vs and a rd_ok flag; fifo_data_out is sampled here.
//   Stage 2 = output registers. Latency from counter value to output pins = 2 pclk, identical for all signals.
// - At stage 1 with de=1:
//   - rd_ok=1 -> rgb = fifo_data_out.
//   - rd_ok=0 && state!=STATE_WAIT_SYNC -> rgb = UNDERRUN_COLOR, pulse underrun, underrun_count += 1.
//     The count saturates at 16'hFFFF.
//   - STATE_WAIT_SYNC pixels -> UNDERRUN_COLOR with no underrun pulse.
// - FSM (decision taken at h_cnt==0 && v_cnt==0, and on stage-0 de pixels):
//   - STATE_WAIT_SYNC -> STATE_RUN at frame origin if enable && !fifo_empty.
//   - STATE_RUN -> STATE_UNDERRUN on a de0 pixel with fifo_empty=1. That pixel is already counted as
//     underrun; further pixels in the frame are blank with no reads and no extra underrun pulses.
//   - STATE_UNDERRUN -> STATE_RUN at frame origin if enable && !fifo_empty, else -> STATE_WAIT_SYNC.
//   - Any state -> STATE_WAIT_SYNC at frame origin when enable=0. enable=0 mid-frame finishes the
//     frame's reads (no partial-frame drop).
// - frame_start pulses on the output cycle that carries h=0,v=0 with state RUN.
// - Simultaneous fifo_empty deassert and frame origin: the !fifo_empty value sampled that cycle decides.
// - Reset mid-frame: everything returns to reset values immediately; no FIFO read is issued until re-lock.
// STRUCTURE
// - Shared package/header hdmi_pkg:
//   - state localparams STATE_WAIT_SYNC=2'd0, STATE_RUN=2'd1, STATE_UNDERRUN=2'd2;
//   - 24-bit pixel packing order {r,g,b}, shared with hdmi_rx;
//   - standard timing constant sets (640x480, 1024x768).
// - One sub-module: hdmi_timing_gen (h/v counters + de0/hs0/vs0 + frame-origin strobe),
//   reusable by test-pattern generators. FSM, read control and output pipeline stay in this module.
// TESTING (small raster: H 8/2/2/2, V 4/1/1/1 -> H_TOTAL 14, V_TOTAL 7, HS_POL=VS_POL=0)
// - Release reset, FIFO empty, enable=1 -> no fifo_read_enable; de pulses 8 cycles in every 14;
//   hsync low for 2 cycles at h=10..11 (pins 2 cycles later); rgb 0; underrun 0.
// - Preload 32 words 0x000001.. -> lock at next origin; frame_start with rgb=0x000001;
//   pixels appear in order, 8 per line; exactly 32 reads/frame; no underrun.
// - Preload 13 words -> pixels 1..13 out, pixel 14 = UNDERRUN_COLOR with one underrun pulse,
//   rest of frame blank; underrun_count=1; relock next frame once the FIFO is refilled.
// - Hold underrun every frame for 70000 frames (forced counter) -> underrun_count sticks at 16'hFFFF.
// - enable dropped mid-frame 2 -> frame 2 completes its 32 reads; frame 3 is blank with no reads;
//   re-enable -> locks at the following origin.
// - Assert reset at h=5, v=2 during RUN -> all outputs reach reset values asynchronously;
//   fifo_read_enable=0 until the next lock.

Source files
------------

// File: rtl/hdmi_pkg.sv
// Shared HDMI definitions: FSM states, pixel packing and standard raster timings.
package hdmi_pkg;

  typedef enum logic [1:0] {
    STATE_WAIT_SYNC = 2'd0,
    STATE_RUN       = 2'd1,
    STATE_UNDERRUN  = 2'd2
  } state_e;

  // 24-bit pixel word is {red, green, blue}; the receive path uses the same order.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  // 640x480 @ 60 Hz
  localparam int T640_H_ACTIVE  = 640;
  localparam int T640_H_FP      = 16;
  localparam int T640_H_SYNC    = 96;
  localparam int T640_H_BP      = 48;
  localparam int T640_V_ACTIVE  = 480;
  localparam int T640_V_FP      = 10;
  localparam int T640_V_SYNC    = 2;
  localparam int T640_V_BP      = 33;

  // 1024x768 @ 60 Hz
  localparam int T1024_H_ACTIVE = 1024;
  localparam int T1024_H_FP     = 24;
  localparam int T1024_H_SYNC   = 136;
  localparam int T1024_H_BP     = 160;
  localparam int T1024_V_ACTIVE = 768;
  localparam int T1024_V_FP     = 3;
  localparam int T1024_V_SYNC   = 6;
  localparam int T1024_V_BP     = 29;

endpackage

// File: rtl/hdmi_tx_pixel_gen_if.sv
// Frame-FIFO read port between the pixel generator and the FIFO.
interface hdmi_tx_pixel_gen_if;
  logic [23:0] fifo_data_out;     // {r,g,b}, valid one cycle after a read
  logic        fifo_empty;
  logic        fifo_read_enable;

  modport master (
    input  fifo_data_out,
    input  fifo_empty,
    output fifo_read_enable
  );

  modport slave (
    output fifo_data_out,
    output fifo_empty,
    input  fifo_read_enable
  );
endinterface

// File: rtl/hdmi_timing_gen.sv
// Raster counters with stage-0 de/hsync/vsync windows and a frame-origin strobe.
// Sync outputs are "in window" flags; polarity is applied by the user.
module hdmi_timing_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter int CNT_W    = 12
) (
  input  logic pclk,
  input  logic reset,
  output logic de0_o,
  output logic hs0_o,
  output logic vs0_o,
  output logic origin_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

  // h wraps at end of line and advances v; v wraps at end of frame
  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == CNT_W'(H_TOTAL - 1)) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == CNT_W'(V_TOTAL - 1)) ? '0 : v_cnt_q + 1'b1;
    end
  end

  // counter registers
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign de0_o    = (h_cnt_q < CNT_W'(H_ACTIVE)) && (v_cnt_q < CNT_W'(V_ACTIVE));
  assign hs0_o    = (h_cnt_q >= CNT_W'(H_ACTIVE + H_FP)) &&
                    (h_cnt_q <  CNT_W'(H_ACTIVE + H_FP + H_SYNC));
  // depends on v only, so it changes when h wraps to 0
  assign vs0_o    = (v_cnt_q >= CNT_W'(V_ACTIVE + V_FP)) &&
                    (v_cnt_q <  CNT_W'(V_ACTIVE + V_FP + V_SYNC));
  assign origin_o = (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: rtl/hdmi_tx_pixel_gen.sv
// HDMI transmit pixel generator: pulls RGB words from the frame FIFO and emits
// a timed raster (2-cycle pipeline) with underrun blanking and frame re-lock.
module hdmi_tx_pixel_gen
  import hdmi_pkg::*;
#(
  parameter int          H_ACTIVE       = T1024_H_ACTIVE,
  parameter int          H_FP           = T1024_H_FP,
  parameter int          H_SYNC         = T1024_H_SYNC,
  parameter int          H_BP           = T1024_H_BP,
  parameter int          V_ACTIVE       = T1024_V_ACTIVE,
  parameter int          V_FP           = T1024_V_FP,
  parameter int          V_SYNC         = T1024_V_SYNC,
  parameter int          V_BP           = T1024_V_BP,
  parameter bit          HS_POL         = 1'b0,
  parameter bit          VS_POL         = 1'b0,
  parameter logic [23:0] UNDERRUN_COLOR = 24'h000000,
  parameter int          CNT_W          = 12
) (
  input  logic                 pclk,
  input  logic                 reset,
  input  logic                 enable,
  hdmi_tx_pixel_gen_if.master  fifo,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic [7:0]           red,
  output logic [7:0]           green,
  output logic [7:0]           blue,
  output logic                 frame_start,
  output logic                 underrun,
  output logic [15:0]          underrun_count
);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic de0, hs0, vs0, origin0;

  hdmi_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CNT_W(CNT_W)
  ) u_timing (
    .pclk    (pclk),
    .reset   (reset),
    .de0_o   (de0),
    .hs0_o   (hs0),
    .vs0_o   (vs0),
    .origin_o(origin0)
  );

  // ---- stage 0: FSM and FIFO read control ----
  state_e state_q, state_d, state_cur;
  logic   rd_en, ur0, fs0;

  // state register
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) state_q <= STATE_WAIT_SYNC;
    else       state_q <= state_d;
  end

  // Lock decision at the frame origin takes effect on the origin pixel itself,
  // so the first read of a locked frame happens on that cycle. Reset blocks
  // the lock so no read is issued while reset is held.
  always_comb begin
    state_cur = state_q;
    state_d   = state_q;
    rd_en     = 1'b0;
    ur0       = 1'b0;
    fs0       = 1'b0;
    if (origin0 && !reset) begin
      state_cur = (enable && !fifo.fifo_empty) ? STATE_RUN : STATE_WAIT_SYNC;
    end
    state_d = state_cur;
    if (de0 && (state_cur == STATE_RUN)) begin
      if (fifo.fifo_empty) begin
        state_d = STATE_UNDERRUN;
        ur0     = 1'b1;
      end else begin
        rd_en   = 1'b1;
      end
    end
    fs0 = origin0 && (state_cur == STATE_RUN);
  end

  assign fifo.fifo_read_enable = rd_en;

  // ---- stage 1: delayed timing, read-ok flag; FIFO data arrives here ----
  logic de_p1_q, hs_p1_q, vs_p1_q, rd_ok_p1_q, ur_p1_q, fs_p1_q;

  // align timing flags with the FIFO read latency
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      de_p1_q    <= 1'b0;
      hs_p1_q    <= 1'b0;
      vs_p1_q    <= 1'b0;
      rd_ok_p1_q <= 1'b0;
      ur_p1_q    <= 1'b0;
      fs_p1_q    <= 1'b0;
    end else begin
      de_p1_q    <= de0;
      hs_p1_q    <= hs0;
      vs_p1_q    <= vs0;
      rd_ok_p1_q <= rd_en;
      ur_p1_q    <= ur0;
      fs_p1_q    <= fs0;
    end
  end

  // ---- stage 2: output registers ----
  pixel_t      px_q;
  logic        hsync_q, vsync_q, de_q, fs_q, ur_q;
  logic [15:0] ucnt_q;

  // drive pins: polarity, pixel select with underrun blanking, underrun count
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      de_q    <= 1'b0;
      px_q    <= '0;
      fs_q    <= 1'b0;
      ur_q    <= 1'b0;
      ucnt_q  <= '0;
    end else begin
      hsync_q <= hs_p1_q ? HS_POL : ~HS_POL;
      vsync_q <= vs_p1_q ? VS_POL : ~VS_POL;
      de_q    <= de_p1_q;
      if (!de_p1_q)        px_q <= '0;
      else if (rd_ok_p1_q) px_q <= pixel_t'(fifo.fifo_data_out);
      else                 px_q <= pixel_t'(UNDERRUN_COLOR);
      fs_q    <= fs_p1_q;
      ur_q    <= ur_p1_q;
      if (ur_p1_q) ucnt_q <= sat_inc16(ucnt_q);
    end
  end

  assign hsync          = hsync_q;
  assign vsync          = vsync_q;
  assign de             = de_q;
  assign red            = px_q.r;
  assign green          = px_q.g;
  assign blue           = px_q.b;
  assign frame_start    = fs_q;
  assign underrun       = ur_q;
  assign underrun_count = ucnt_q;

endmodule

// File: tb/tb_hdmi_tx_pixel_gen.sv
// Bench for hdmi_tx_pixel_gen on a 14x7 raster (H 8/2/2/2, V 4/1/1/1).
module tb_hdmi_tx_pixel_gen;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;   // 14
  localparam int VT = VA + VF + VS + VB;   // 7
  localparam int FT = HT * VT;             // 98 cycles per frame

  typedef struct {
    int words; bit en;
    int rd; int good; int blank; int ur; int fs; int ucnt;
  } vec_t;

  logic pclk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  always #5 pclk = ~pclk;

  hdmi_tx_pixel_gen_if fif ();
  logic        hsync, vsync, de, frame_start, underrun;
  logic [7:0]  red, green, blue;
  logic [15:0] underrun_count;
  logic [23:0] rgb;
  assign rgb = {red, green, blue};

  hdmi_tx_pixel_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .UNDERRUN_COLOR(24'h000000), .CNT_W(12)
  ) dut (
    .pclk(pclk), .reset(reset), .enable(enable), .fifo(fif),
    .hsync(hsync), .vsync(vsync), .de(de),
    .red(red), .green(green), .blue(blue),
    .frame_start(frame_start), .underrun(underrun), .underrun_count(underrun_count)
  );

  // FIFO model: data registered one cycle after the read strobe
  logic [23:0] mem [0:511];
  int          f_wr = 0;
  int          f_rd = 0;
  logic [23:0] fdata = '0;
  assign fif.fifo_empty    = (f_rd == f_wr);
  assign fif.fifo_data_out = fdata;
  always @(posedge pclk) begin
    if (fif.fifo_read_enable) begin
      fdata <= mem[f_rd];
      f_rd  <= f_rd + 1;
    end
  end

  int errors = 0, checks = 0;
  int m = 0;
  int acc_rd = 0, s_rd = 0;
  int p_good = 0, p_blank = 0, p_ur = 0, p_fs = 0;
  int s_good = 0, s_blank = 0, s_ur = 0, s_fs = 0;
  int exp_ptr = 0;
  vec_t vt [7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at m=%0d", name, act, act, exp, exp, m);
    end
  endtask

  function automatic bit m_de(input int k);
    return ((k % HT) < HA) && (((k / HT) % VT) < VA);
  endfunction
  function automatic bit m_hs(input int k);
    return !(((k % HT) >= HA + HF) && ((k % HT) < HA + HF + HS));
  endfunction
  function automatic bit m_vs(input int k);
    return !((((k / HT) % VT) >= VA + VF) && (((k / HT) % VT) < VA + VF + VS));
  endfunction

  task automatic preload(input int n);
    for (int i = 0; i < n; i++) begin
      mem[f_wr] = 24'(f_wr + 1);
      f_wr = f_wr + 1;
    end
  endtask

  // read strobe belongs to the counter value m itself
  task automatic stage0_sample();
    if (m % FT == 0) acc_rd = 0;
    if (fif.fifo_read_enable) begin
      acc_rd++;
      check("rd_while_empty", int'(fif.fifo_empty), 0);
      check("rd_outside_de", int'(m_de(m)), 1);
    end
    if (m % FT == FT - 1) s_rd = acc_rd;
  endtask

  // pins carry the counter value from two cycles earlier
  task automatic pin_sample();
    int k;
    if (m < 2) return;
    k = m - 2;
    if (k % FT == 0) begin
      p_good = 0; p_blank = 0; p_ur = 0; p_fs = 0;
    end
    check("timing", int'({de, hsync, vsync}), int'({m_de(k), m_hs(k), m_vs(k)}));
    if (de) begin
      if (rgb == 24'h0) p_blank++;
      else begin
        check("pixel", int'(rgb), int'(mem[exp_ptr]));
        exp_ptr++;
        p_good++;
      end
    end else begin
      check("rgb_outside_de", int'(rgb), 0);
    end
    if (underrun) begin
      p_ur++;
      check("underrun_pixel", int'({de, rgb == 24'h0}), 3);
    end
    if (frame_start) begin
      p_fs++;
      check("frame_start_pos", k % FT, 0);
    end
    if (k % FT == FT - 1) begin
      s_good = p_good; s_blank = p_blank; s_ur = p_ur; s_fs = p_fs;
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
    m++;
    stage0_sample();
    pin_sample();
  endtask

  task automatic run_to(input int target);
    while (m < target) tick();
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".hsync"}, int'(hsync), 1);
    check({tag, ".vsync"}, int'(vsync), 1);
    check({tag, ".de"}, int'(de), 0);
    check({tag, ".rgb"}, int'(rgb), 0);
    check({tag, ".frame_start"}, int'(frame_start), 0);
    check({tag, ".underrun"}, int'(underrun), 0);
    check({tag, ".underrun_count"}, int'(underrun_count), 0);
    check({tag, ".rd_en"}, int'(fif.fifo_read_enable), 0);
  endtask

  task automatic release_reset();
    @(negedge pclk);
    reset = 1'b0;
    m = 0;
    acc_rd = 0; p_good = 0; p_blank = 0; p_ur = 0; p_fs = 0;
    #1;
    stage0_sample();
  endtask

  task automatic check_frame(input vec_t v, input string tag);
    check({tag, ".reads"}, s_rd, v.rd);
    check({tag, ".good_px"}, s_good, v.good);
    check({tag, ".blank_px"}, s_blank, v.blank);
    check({tag, ".underruns"}, s_ur, v.ur);
    check({tag, ".frame_start"}, s_fs, v.fs);
    check({tag, ".underrun_count"}, int'(underrun_count), v.ucnt);
  endtask

  // preload in blanking of frame F, target frame F+1, check during frame F+2
  task automatic run_vector(input vec_t v, input string tag);
    preload(v.words);
    enable = v.en;
    run_to(m + 2 * FT);
    check_frame(v, tag);
  endtask

  initial begin
    int fr, rd_start;
    //        words en  rd good blank ur fs ucnt
    vt[0] = '{0,    1,  0,  0,  32,   0, 0, 0};
    vt[1] = '{32,   1, 32, 32,   0,   0, 1, 0};
    vt[2] = '{13,   1, 13, 13,  19,   1, 1, 1};
    vt[3] = '{32,   0,  0,  0,  32,   0, 0, 1};
    vt[4] = '{0,    1, 32, 32,   0,   0, 1, 1};
    vt[5] = '{1,    1,  1,  1,  31,   1, 1, 2};
    vt[6] = '{32,   1, 32, 32,   0,   0, 1, 2};

    reset  = 1'b1;
    enable = 1'b1;
    #12;
    check_reset("reset_init");
    release_reset();
    run_to(60);

    for (int i = 0; i < 7; i++) run_vector(vt[i], $sformatf("vec%0d", i));

    // enable dropped mid-frame: locked frame finishes, next frame blank, then relock
    fr = m / FT;
    preload(32);
    enable = 1'b1;
    run_to((fr + 1) * FT + 20);
    enable = 1'b0;
    run_to((fr + 1) * FT + 60);
    preload(32);
    run_to((fr + 2) * FT + 30);
    check_frame('{0, 0, 32, 32, 0, 0, 1, 2}, "endrop.finish");
    enable = 1'b1;
    run_to((fr + 3) * FT + 60);
    check_frame('{0, 0, 0, 0, 32, 0, 0, 2}, "endrop.blank");
    run_to((fr + 4) * FT + 60);
    check_frame('{0, 0, 32, 32, 0, 0, 1, 2}, "endrop.relock");

    // saturation of the underrun counter from a preset value
    force dut.ucnt_q = 16'hFFFE;
    #1;
    release dut.ucnt_q;
    run_vector('{1, 1, 1, 1, 31, 1, 1, 32'hFFFF}, "sat1");
    run_vector('{1, 1, 1, 1, 31, 1, 1, 32'hFFFF}, "sat2");

    // asynchronous reset at h=5, v=2 of a locked frame
    fr = m / FT;
    rd_start = f_rd;
    preload(32);
    enable = 1'b1;
    run_to((fr + 1) * FT + 2 * HT + 5);
    #1;
    reset = 1'b1;
    #1;
    check_reset("reset_mid");
    for (int i = 0; i < 3; i++) begin
      @(posedge pclk);
      #1;
      check("rd_in_reset", int'(fif.fifo_read_enable), 0);
    end
    check("reads_before_reset", f_rd - rd_start, 21);
    exp_ptr = f_rd;
    release_reset();
    run_to(FT + 60);
    check_frame('{0, 1, 11, 11, 21, 1, 1, 1}, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
